ps2_cmd_scheduler: RTL and testbench

- Sequences the shared PS/2 PHY (`ps2_rx_tx_driver`).
- Runs the power-up handshake: reset, BAT, ID, enable reporting.
- Forwards stream bytes to the packet assembler.
- Arbitrates one host command port onto the PHY transmit path, with ACK/RESEND/timeout handling.
- Sits between the PHY and the mouse packet decoder.

---
 rtl/ps2_pkg.sv | 41 ++++
 rtl/ps2_cmd_scheduler_if.sv | 41 ++++
 rtl/ps2_timeout_timer.sv | 33 +++
 rtl/ps2_cmd_scheduler.sv | 168 ++++++++++++++++
 tb/tb_ps2_cmd_scheduler.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 command/response byte values and the scheduler state encoding.
package ps2_pkg;

    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] CMD_ENABLE   = 8'hF4;
    localparam logic [7:0] CMD_DISABLE  = 8'hF5;
    localparam logic [7:0] CMD_SET_RATE = 8'hF3;
    localparam logic [7:0] CMD_SET_RES  = 8'hE8;

    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;
    localparam logic [7:0] RSP_ERROR  = 8'hFC;
    localparam logic [7:0] RSP_BAT_OK = 8'hAA;
    localparam logic [7:0] RSP_ID_STD = 8'h00;

    // TX_RST is zero so the debug port reads 0 straight out of reset.
    typedef enum logic [3:0] {
        TX_RST    = 4'd0,
        WAIT_RACK = 4'd1,
        WAIT_BAT  = 4'd2,
        WAIT_ID   = 4'd3,
        TX_EN     = 4'd4,
        WAIT_EACK = 4'd5,
        STREAM    = 4'd6,
        TX_CMD    = 4'd7,
        WAIT_CACK = 4'd8,
        TX_ARG    = 4'd9,
        WAIT_AACK = 4'd10,
        DONE      = 4'd11
    } ps2_state_t;

    function automatic logic is_tx_state(input ps2_state_t s);
        return (s == TX_RST) || (s == TX_EN) || (s == TX_CMD) || (s == TX_ARG);
    endfunction

    function automatic logic is_wait_state(input ps2_state_t s);
        return (s == WAIT_RACK) || (s == WAIT_BAT) || (s == WAIT_ID) ||
               (s == WAIT_EACK) || (s == WAIT_CACK) || (s == WAIT_AACK);
    endfunction

endpackage

// File: rtl/ps2_cmd_scheduler_if.sv
// Bundle of PHY, host-command and stream signals around the PS/2 command scheduler.
interface ps2_cmd_scheduler_if;

    logic       phy_wr_en;
    logic [7:0] phy_din;
    logic [7:0] phy_dout;
    logic       phy_rx_done;
    logic       phy_tx_done;

    logic       cmd_req;
    logic [7:0] cmd_byte;
    logic       cmd_has_arg;
    logic [7:0] cmd_arg;
    logic       cmd_busy;
    logic       cmd_done;
    logic       cmd_err;

    logic [7:0] stream_byte;
    logic       stream_valid;
    logic       stream_resync;
    logic       init_done;
    logic [3:0] state_dbg;

    // master is the scheduler itself; slave is the PHY/host/assembler side.
    modport master (
        output phy_wr_en, phy_din,
        input  phy_dout, phy_rx_done, phy_tx_done,
        input  cmd_req, cmd_byte, cmd_has_arg, cmd_arg,
        output cmd_busy, cmd_done, cmd_err,
        output stream_byte, stream_valid, stream_resync, init_done, state_dbg
    );

    modport slave (
        input  phy_wr_en, phy_din,
        output phy_dout, phy_rx_done, phy_tx_done,
        output cmd_req, cmd_byte, cmd_has_arg, cmd_arg,
        input  cmd_busy, cmd_done, cmd_err,
        input  stream_byte, stream_valid, stream_resync, init_done, state_dbg
    );

endinterface

// File: rtl/ps2_timeout_timer.sv
// Loadable down-counter shared by the ACK and BAT waits; clear restarts from the last load value.
module ps2_timeout_timer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             clear,
    input  logic             enable,
    output logic             expired
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] reload;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count  <= '0;
            reload <= '0;
        end else if (load) begin
            count  <= load_value;
            reload <= load_value;
        end else if (clear) begin
            count <= reload;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && !load && !clear && (count == '0);

endmodule

// File: rtl/ps2_cmd_scheduler.sv
// Sequences the PS/2 PHY: power-up handshake, stream forwarding and host commands with retry.
module ps2_cmd_scheduler
    import ps2_pkg::*;
#(
    parameter int ACK_TIMEOUT = 750000,
    parameter int BAT_TIMEOUT = 40000000,
    parameter int MAX_RETRY   = 3
) (
    input  logic clk,
    input  logic reset,
    ps2_cmd_scheduler_if.master bus
);

    localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);

    ps2_state_t  state;
    logic [7:0]  cmd_byte_q;
    logic [7:0]  cmd_arg_q;
    logic        has_arg_q;
    logic [7:0]  retry;

    logic        rx_ack;
    logic        rx_resend;
    logic        rx_error;
    logic        timer_load;
    logic [31:0] timer_value;
    logic        timer_expired;

    // BAT waits get the long timeout; every transmit rearms the ACK timeout.
    always_comb begin
        rx_ack      = bus.phy_rx_done && (bus.phy_dout == RSP_ACK);
        rx_resend   = bus.phy_rx_done && (bus.phy_dout == RSP_RESEND);
        rx_error    = bus.phy_rx_done && (bus.phy_dout == RSP_ERROR);
        timer_load  = 1'b0;
        timer_value = 32'(ACK_TIMEOUT);
        if (is_tx_state(state)) begin
            timer_load = 1'b1;
        end else if ((state == WAIT_RACK) && rx_ack) begin
            timer_load  = 1'b1;
            timer_value = 32'(BAT_TIMEOUT);
        end else if ((state == WAIT_BAT) && bus.phy_rx_done && (bus.phy_dout == RSP_BAT_OK)) begin
            timer_load  = 1'b1;
            timer_value = 32'(BAT_TIMEOUT);
        end
    end

    ps2_timeout_timer #(.WIDTH(32)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .clear      (bus.phy_tx_done),
        .enable     (is_wait_state(state)),
        .expired    (timer_expired)
    );

    assign bus.state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= TX_RST;
            retry             <= '0;
            cmd_byte_q        <= '0;
            cmd_arg_q         <= '0;
            has_arg_q         <= 1'b0;
            bus.phy_wr_en     <= 1'b0;
            bus.phy_din       <= '0;
            bus.cmd_busy      <= 1'b0;
            bus.cmd_done      <= 1'b0;
            bus.cmd_err       <= 1'b0;
            bus.stream_byte   <= '0;
            bus.stream_valid  <= 1'b0;
            bus.stream_resync <= 1'b0;
            bus.init_done     <= 1'b0;
        end else begin
            bus.phy_wr_en     <= 1'b0;
            bus.stream_valid  <= 1'b0;
            bus.stream_resync <= 1'b0;
            bus.cmd_done      <= 1'b0;
            bus.cmd_err       <= 1'b0;
            case (state)
                TX_RST: begin
                    bus.phy_wr_en <= 1'b1;
                    bus.phy_din   <= CMD_RESET;
                    bus.init_done <= 1'b0;
                    state         <= WAIT_RACK;
                end
                WAIT_RACK: begin
                    if (bus.phy_rx_done) state <= rx_ack ? WAIT_BAT : TX_RST;
                    else if (timer_expired) state <= TX_RST;
                end
                WAIT_BAT: begin
                    if (bus.phy_rx_done && (bus.phy_dout == RSP_BAT_OK)) state <= WAIT_ID;
                    else if (rx_error || timer_expired) state <= TX_RST;
                end
                WAIT_ID: begin
                    if (bus.phy_rx_done) state <= (bus.phy_dout == RSP_ID_STD) ? TX_EN : TX_RST;
                    else if (timer_expired) state <= TX_RST;
                end
                TX_EN: begin
                    bus.phy_wr_en <= 1'b1;
                    bus.phy_din   <= CMD_ENABLE;
                    state         <= WAIT_EACK;
                end
                WAIT_EACK: begin
                    if (rx_ack) begin
                        bus.stream_resync <= 1'b1;
                        bus.init_done     <= 1'b1;
                        state             <= STREAM;
                    end else if (bus.phy_rx_done || timer_expired) begin
                        state <= TX_RST;
                    end
                end
                // The done/err pulse is still visible while the requester drops cmd_req.
                STREAM: begin
                    if (bus.phy_rx_done) begin
                        bus.stream_valid <= 1'b1;
                        bus.stream_byte  <= bus.phy_dout;
                    end
                    if (bus.cmd_req && !bus.cmd_done && !bus.cmd_err) begin
                        cmd_byte_q   <= bus.cmd_byte;
                        cmd_arg_q    <= bus.cmd_arg;
                        has_arg_q    <= bus.cmd_has_arg;
                        retry        <= '0;
                        bus.cmd_busy <= 1'b1;
                        state        <= TX_CMD;
                    end
                end
                TX_CMD: begin
                    bus.phy_wr_en <= 1'b1;
                    bus.phy_din   <= cmd_byte_q;
                    state         <= WAIT_CACK;
                end
                TX_ARG: begin
                    bus.phy_wr_en <= 1'b1;
                    bus.phy_din   <= cmd_arg_q;
                    state         <= WAIT_AACK;
                end
                WAIT_CACK, WAIT_AACK: begin
                    if (rx_ack) begin
                        if ((state == WAIT_CACK) && has_arg_q) begin
                            retry <= '0;
                            state <= TX_ARG;
                        end else begin
                            state <= DONE;
                        end
                    end else if (rx_error || ((rx_resend || timer_expired) && (retry >= RETRY_LIMIT))) begin
                        bus.cmd_err       <= 1'b1;
                        bus.cmd_busy      <= 1'b0;
                        bus.stream_resync <= 1'b1;
                        state             <= STREAM;
                    end else if (rx_resend || timer_expired) begin
                        retry <= retry + 8'd1;
                        state <= (state == WAIT_CACK) ? TX_CMD : TX_ARG;
                    end
                end
                DONE: begin
                    bus.cmd_done      <= 1'b1;
                    bus.cmd_busy      <= 1'b0;
                    bus.stream_resync <= 1'b1;
                    state             <= STREAM;
                end
                default: state <= TX_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_cmd_scheduler.sv
// Self-checking bench: a reactive PHY model plus a transaction-level model of the command retry rules.
module tb_ps2_cmd_scheduler;
    import ps2_pkg::*;

    localparam int ACK_TO    = 100;
    localparam int BAT_TO    = 400;
    localparam int RETRIES   = 3;
    localparam int TX_LAT    = 2;
    localparam int REPLY_GAP = 3;
    localparam int NO_REPLY  = -1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ps2_cmd_scheduler_if bus();

    ps2_cmd_scheduler #(
        .ACK_TIMEOUT (ACK_TO),
        .BAT_TIMEOUT (BAT_TO),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cycle = 0;

    logic [7:0] tx_log[$];
    int         tx_cyc[$];
    logic [7:0] sv_log[$];
    int         sv_cyc[$];
    int         burst_q[$];
    int         reply_q[$];
    int         pend[$];
    int         plan[$];
    logic [7:0] exp_tx[$];
    int         txd_cnt = 0;
    int         gap_cnt = 0;
    int         inj_wait = 0;
    logic [7:0] inj_byte = 8'h00;
    int         inj_cyc = 0;
    int         resync_cnt = 0;
    int         done_cnt = 0;
    int         err_cnt = 0;

    // One clock of the PHY model: observe DUT outputs, then drive PHY strobes for the next edge.
    task automatic tick();
        @(negedge clk);
        cycle++;
        bus.phy_rx_done = 1'b0;
        bus.phy_tx_done = 1'b0;
        if (bus.phy_wr_en === 1'b1) begin
            int n;
            tx_log.push_back(bus.phy_din);
            tx_cyc.push_back(cycle);
            txd_cnt = TX_LAT;
            n = (burst_q.size() > 0) ? burst_q.pop_front() : 0;
            for (int i = 0; i < n; i++)
                if (reply_q.size() > 0) pend.push_back(reply_q.pop_front());
        end
        if (bus.stream_valid === 1'b1) begin
            sv_log.push_back(bus.stream_byte);
            sv_cyc.push_back(cycle);
        end
        if (bus.stream_resync === 1'b1) resync_cnt++;
        if (bus.cmd_done === 1'b1) done_cnt++;
        if (bus.cmd_err === 1'b1) err_cnt++;
        if (txd_cnt > 0) begin
            txd_cnt--;
            if (txd_cnt == 0) begin
                bus.phy_tx_done = 1'b1;
                gap_cnt = REPLY_GAP;
            end
        end else if (pend.size() > 0) begin
            if (gap_cnt > 0) gap_cnt--;
            else begin
                bus.phy_rx_done = 1'b1;
                bus.phy_dout    = 8'(pend.pop_front());
                gap_cnt         = REPLY_GAP;
            end
        end
        if (inj_wait > 0) begin
            inj_wait--;
            if (inj_wait == 0) begin
                bus.phy_rx_done = 1'b1;
                bus.phy_dout    = inj_byte;
                inj_cyc         = cycle;
            end
        end
    endtask

    task automatic clear_phy_model();
        burst_q.delete(); reply_q.delete(); pend.delete();
        tx_log.delete(); tx_cyc.delete(); sv_log.delete(); sv_cyc.delete();
        txd_cnt = 0; gap_cnt = 0; inj_wait = 0;
    endtask

    task automatic set_plan(input int n, input int r0, input int r1, input int r2, input int r3, input int r4);
        int r[5];
        r[0] = r0; r[1] = r1; r[2] = r2; r[3] = r3; r[4] = r4;
        plan.delete();
        for (int i = 0; i < n; i++) plan.push_back(r[i]);
    endtask

    // Reference: walk the reply script one transmit at a time using the ACK/RESEND/ERROR rules.
    task automatic model_cmd(input logic [7:0] c, input logic [7:0] a, input bit ha, output int result);
        int idx = 0;
        int retries = 0;
        bit arg_phase = 1'b0;
        int r;
        exp_tx.delete();
        result = 0;
        while (result == 0) begin
            exp_tx.push_back(arg_phase ? a : c);
            r = (idx < plan.size()) ? plan[idx] : NO_REPLY;
            idx++;
            if (r == 'hFA) begin
                if (ha && !arg_phase) begin
                    arg_phase = 1'b1;
                    retries   = 0;
                end else result = 1;
            end else if (r == 'hFC) result = 2;
            else if (retries < RETRIES) retries++;
            else result = 2;
        end
    endtask

    function automatic bit seq_equal();
        if (tx_log.size() != exp_tx.size()) return 1'b0;
        foreach (tx_log[i]) if (tx_log[i] !== exp_tx[i]) return 1'b0;
        return 1'b1;
    endfunction

    // Issue one host command with the reply script in plan; result 1=done, 2=err, 0=no outcome.
    task automatic run_cmd(input logic [7:0] c, input logic [7:0] a, input bit ha,
                           input int inj_delay, input logic [7:0] ib,
                           output int result, output bit busy_seen);
        int d0 = done_cnt;
        int e0 = err_cnt;
        clear_phy_model();
        foreach (plan[i]) begin
            if (plan[i] < 0) burst_q.push_back(0);
            else begin
                burst_q.push_back(1);
                reply_q.push_back(plan[i]);
            end
        end
        tick();
        bus.cmd_req     = 1'b1;
        bus.cmd_byte    = c;
        bus.cmd_arg     = a;
        bus.cmd_has_arg = ha;
        if (inj_delay == 0) begin
            bus.phy_rx_done = 1'b1;
            bus.phy_dout    = ib;
            inj_cyc         = cycle;
        end else if (inj_delay > 0) begin
            inj_byte = ib;
            inj_wait = inj_delay;
        end
        result    = 0;
        busy_seen = 1'b0;
        for (int b = 0; b < 3000 && result == 0; b++) begin
            tick();
            if (bus.cmd_busy === 1'b1) busy_seen = 1'b1;
            if (done_cnt != d0) result = 1;
            else if (err_cnt != e0) result = 2;
        end
        bus.cmd_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (bus.phy_wr_en !== 1'b0) begin bad++; $display("[TB] FAIL reset_wr_en: got %b want 0", bus.phy_wr_en); end
        total++; if (bus.phy_din !== 8'h00) begin bad++; $display("[TB] FAIL reset_din: got %h want 00", bus.phy_din); end
        total++; if (bus.state_dbg !== 4'd0) begin bad++; $display("[TB] FAIL reset_state: got %0d want 0", bus.state_dbg); end
        total++; if ({bus.cmd_busy, bus.cmd_done, bus.cmd_err, bus.stream_valid, bus.stream_resync, bus.init_done} !== 6'b0) begin
            bad++; $display("[TB] FAIL reset_flags: got %b want 000000",
                            {bus.cmd_busy, bus.cmd_done, bus.cmd_err, bus.stream_valid, bus.stream_resync, bus.init_done});
        end
    endtask

    task automatic test_powerup();
        int r0 = resync_cnt;
        clear_phy_model();
        burst_q.push_back(3); reply_q.push_back('hFA); reply_q.push_back('hAA); reply_q.push_back('h00);
        burst_q.push_back(1); reply_q.push_back('hFA);
        reset = 1'b0;
        for (int b = 0; b < 500 && bus.init_done !== 1'b1; b++) tick();
        tick();
        total++; if (bus.init_done !== 1'b1) begin bad++; $display("[TB] FAIL powerup_init: got %b want 1", bus.init_done); end
        exp_tx.delete(); exp_tx.push_back(8'hFF); exp_tx.push_back(8'hF4);
        total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL powerup_tx: got %0d bytes (first %h) want FF,F4", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'h00); end
        total++; if (resync_cnt - r0 != 1) begin bad++; $display("[TB] FAIL powerup_resync: got %0d pulses want 1", resync_cnt - r0); end
    endtask

    task automatic test_stream();
        logic [7:0] bytes[6];
        bytes[0] = 8'h08; bytes[1] = 8'h05; bytes[2] = 8'hFB;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        sv_log.delete(); sv_cyc.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            bus.phy_rx_done = 1'b1;
            bus.phy_dout    = bytes[i];
            inj_cyc         = cycle;
            tick();
            tick();
            total++;
            if (sv_log.size() != i + 1 || sv_log[i] !== bytes[i] || sv_cyc[i] - inj_cyc != 1) begin
                bad++;
                $display("[TB] FAIL stream_byte%0d: got count %0d byte %h latency %0d want count %0d byte %h latency 1",
                         i, sv_log.size(), sv_log.size() > 0 ? sv_log[sv_log.size()-1] : 8'h00,
                         sv_cyc.size() > 0 ? sv_cyc[sv_cyc.size()-1] - inj_cyc : -1, i + 1, bytes[i]);
            end
        end
    endtask

    task automatic test_cmd_ack();
        int res, exp_res;
        bit busy_seen;
        int r0 = resync_cnt;
        set_plan(2, 'hFA, 'hFA, 0, 0, 0);
        model_cmd(8'hF3, 8'h64, 1'b1, exp_res);
        run_cmd(8'hF3, 8'h64, 1'b1, -1, 8'h00, res, busy_seen);
        total++; if (res != exp_res) begin bad++; $display("[TB] FAIL ack_result: got %0d want %0d", res, exp_res); end
        total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL ack_tx: got %0d bytes want %0d (F3,64)", tx_log.size(), exp_tx.size()); end
        total++; if (!busy_seen || bus.cmd_busy !== 1'b0) begin bad++; $display("[TB] FAIL ack_busy: seen %b now %b want 1/0", busy_seen, bus.cmd_busy); end
        total++; if (resync_cnt - r0 != 1) begin bad++; $display("[TB] FAIL ack_resync: got %0d want 1", resync_cnt - r0); end
    endtask

    task automatic test_retry();
        int res, exp_res;
        bit busy_seen;
        set_plan(3, 'hFE, 'hFE, 'hFA, 0, 0);
        model_cmd(8'hE8, 8'h02, 1'b0, exp_res);
        run_cmd(8'hE8, 8'h02, 1'b0, -1, 8'h00, res, busy_seen);
        total++; if (res != exp_res || tx_log.size() != 3) begin bad++; $display("[TB] FAIL resend_done: got result %0d sends %0d want %0d/3", res, tx_log.size(), exp_res); end
        total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL resend_tx: got %0d bytes want %0d", tx_log.size(), exp_tx.size()); end
        set_plan(5, 'hFE, 'hFE, 'hFE, 'hFE, 'hFE);
        model_cmd(8'hE8, 8'h02, 1'b0, exp_res);
        run_cmd(8'hE8, 8'h02, 1'b0, -1, 8'h00, res, busy_seen);
        total++; if (res != 2 || res != exp_res) begin bad++; $display("[TB] FAIL resend_err: got %0d want 2", res); end
        total++; if (tx_log.size() != 1 + RETRIES) begin bad++; $display("[TB] FAIL resend_count: got %0d sends want %0d", tx_log.size(), 1 + RETRIES); end
    endtask

    task automatic test_timeout();
        int res, exp_res, gap;
        bit busy_seen;
        plan.delete();
        model_cmd(8'hF5, 8'h00, 1'b0, exp_res);
        run_cmd(8'hF5, 8'h00, 1'b0, 20, 8'h09, res, busy_seen);
        total++; if (res != 2 || res != exp_res) begin bad++; $display("[TB] FAIL timeout_err: got %0d want 2", res); end
        total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL timeout_tx: got %0d sends want %0d", tx_log.size(), exp_tx.size()); end
        total++; if (sv_log.size() != 0) begin bad++; $display("[TB] FAIL timeout_drop: got %0d forwarded want 0", sv_log.size()); end
        gap = (tx_cyc.size() > 1) ? tx_cyc[1] - tx_cyc[0] : 0;
        total++; if (gap < ACK_TO || gap > ACK_TO + 12) begin bad++; $display("[TB] FAIL timeout_gap: got %0d cycles want %0d..%0d", gap, ACK_TO, ACK_TO + 12); end
    endtask

    task automatic test_back_to_back();
        int res;
        bit busy_seen;
        logic [7:0] b = 8'($urandom_range(0, 255));
        set_plan(1, 'hFA, 0, 0, 0, 0);
        run_cmd(8'hF4, 8'h00, 1'b0, 0, b, res, busy_seen);
        total++; if (res != 1) begin bad++; $display("[TB] FAIL same_cycle_done: got %0d want 1", res); end
        total++; if (sv_log.size() != 1 || sv_log[0] !== b || sv_cyc[0] - inj_cyc != 1) begin
            bad++; $display("[TB] FAIL same_cycle_fwd: got count %0d byte %h want 1/%h", sv_log.size(), sv_log.size() > 0 ? sv_log[0] : 8'h00, b);
        end
        set_plan(1, 'hFA, 0, 0, 0, 0);
        run_cmd(8'hF5, 8'h00, 1'b0, -1, 8'h00, res, busy_seen);
        total++; if (res != 1 || tx_log.size() != 1 || tx_log[0] !== 8'hF5) begin bad++; $display("[TB] FAIL back_to_back: got result %0d sends %0d want 1/1", res, tx_log.size()); end
    endtask

    task automatic test_cmd_random();
        logic [7:0] ops[5];
        int res, exp_res, pick;
        bit busy_seen;
        ops[0] = 8'hF3; ops[1] = 8'hE8; ops[2] = 8'hF5; ops[3] = 8'hF4; ops[4] = 8'hE6;
        for (int t = 0; t < 6; t++) begin
            logic [7:0] c = ops[$urandom_range(0, 4)];
            logic [7:0] a = 8'($urandom_range(0, 255));
            bit ha = (c == 8'hF3) || (c == 8'hE8);
            plan.delete();
            for (int k = 0; k < 6; k++) begin
                pick = $urandom_range(0, 9);
                if (pick <= 5) plan.push_back('hFA);
                else if (pick == 6) plan.push_back('hFE);
                else if (pick == 7) plan.push_back('hFC);
                else if (pick == 8) plan.push_back(NO_REPLY);
                else plan.push_back('h09);
            end
            model_cmd(c, a, ha, exp_res);
            run_cmd(c, a, ha, -1, 8'h00, res, busy_seen);
            total++; if (res != exp_res) begin bad++; $display("[TB] FAIL rand%0d_result: got %0d want %0d (op %h)", t, res, exp_res, c); end
            total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL rand%0d_tx: got %0d sends want %0d (op %h)", t, tx_log.size(), exp_tx.size(), c); end
            total++; if (sv_log.size() != 0 || bus.cmd_busy !== 1'b0) begin bad++; $display("[TB] FAIL rand%0d_idle: got fwd %0d busy %b want 0/0", t, sv_log.size(), bus.cmd_busy); end
        end
    endtask

    task automatic test_init_fail();
        reset = 1'b1;
        tick();
        clear_phy_model();
        burst_q.push_back(3); reply_q.push_back('hFA); reply_q.push_back('hAA); reply_q.push_back('h03);
        burst_q.push_back(3); reply_q.push_back('hFA); reply_q.push_back('hAA); reply_q.push_back('h00);
        burst_q.push_back(1); reply_q.push_back('hFA);
        reset = 1'b0;
        for (int b = 0; b < 800 && bus.init_done !== 1'b1; b++) tick();
        tick();
        exp_tx.delete(); exp_tx.push_back(8'hFF); exp_tx.push_back(8'hFF); exp_tx.push_back(8'hF4);
        total++; if (!seq_equal()) begin bad++; $display("[TB] FAIL bad_id_tx: got %0d bytes want FF,FF,F4", tx_log.size()); end
        total++; if (bus.init_done !== 1'b1) begin bad++; $display("[TB] FAIL bad_id_init: got %b want 1", bus.init_done); end
    endtask

    task automatic test_reset_mid_cmd();
        bit busy_seen = 1'b0;
        clear_phy_model();
        tick();
        bus.cmd_req = 1'b1; bus.cmd_byte = 8'hF5; bus.cmd_has_arg = 1'b0; bus.cmd_arg = 8'h00;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.cmd_busy === 1'b1) busy_seen = 1'b1;
        end
        #2 reset = 1'b1;
        #1;
        total++; if (!busy_seen || {bus.cmd_busy, bus.phy_wr_en, bus.init_done, bus.state_dbg, bus.phy_din} !== 19'b0) begin
            bad++; $display("[TB] FAIL async_reset: busy_seen %b busy %b init %b state %0d din %h want 1/0/0/0/00",
                            busy_seen, bus.cmd_busy, bus.init_done, bus.state_dbg, bus.phy_din);
        end
        bus.cmd_req = 1'b0;
        tick();
        clear_phy_model();
        tick();
        reset = 1'b0;
        for (int b = 0; b < 20 && tx_log.size() == 0; b++) tick();
        total++; if (tx_log.size() == 0 || tx_log[0] !== 8'hFF) begin bad++; $display("[TB] FAIL post_reset_tx: got %0d bytes (first %h) want FF", tx_log.size(), tx_log.size() > 0 ? tx_log[0] : 8'h00); end
    endtask

    initial begin
        bus.phy_dout = 8'h00; bus.phy_rx_done = 1'b0; bus.phy_tx_done = 1'b0;
        bus.cmd_req = 1'b0; bus.cmd_byte = 8'h00; bus.cmd_has_arg = 1'b0; bus.cmd_arg = 8'h00;
        test_reset();
        test_powerup();
        test_stream();
        test_cmd_ack();
        test_retry();
        test_timeout();
        test_back_to_back();
        test_cmd_random();
        test_init_fail();
        test_reset_mid_cmd();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
